// File: rtl/alu_pkg.sv
// alu_pkg
// Shared opcode constants and the sequencer state type used by the ALU
// issue controller and its latency decoder.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_SHR  = 5'h05;
    localparam logic [4:0] OP_SHRA = 5'h06;
    localparam logic [4:0] OP_SHL  = 5'h07;
    localparam logic [4:0] OP_ROR  = 5'h08;
    localparam logic [4:0] OP_ROL  = 5'h09;
    localparam logic [4:0] OP_MUL  = 5'h0A;
    localparam logic [4:0] OP_DIV  = 5'h0B;
    localparam logic [4:0] OP_NEG  = 5'h0C;
    localparam logic [4:0] OP_NOT  = 5'h0D;

    localparam logic [4:0] OP_LAST = 5'b01101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_lat_decode.sv
// alu_lat_decode
// Combinational opcode decoder: settle latency (in cycles) and an error flag
// for the operation about to be issued.
// Ports:
//   op_i        opcode from the request
//   b_is_zero_i request operand B equals zero
//   latency_o   number of cycles the ALU result needs to settle (>= 1)
//   illegal_o   result must be forced to zero and flagged as an error
// Build option: ALU_SEQ_DIV0_TRAP_EN - DIV by zero completes in one cycle
// and is reported as an error instead of running the full divide.
module alu_lat_decode
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int LAT_W      = 4
) (
    input  logic [4:0]       op_i,
    input  logic             b_is_zero_i,
    output logic [LAT_W-1:0] latency_o,
    output logic             illegal_o
);

`ifndef ALU_SEQ_DIV0_TRAP_EN
    // Operand B only matters when the divide-by-zero trap is built in.
    logic unused_b_is_zero;
    assign unused_b_is_zero = b_is_zero_i;
`endif

    always_comb begin
        latency_o = LAT_W'(1);
        illegal_o = 1'b0;
        if (op_i == 5'd0 || op_i > OP_LAST) begin
            illegal_o = 1'b1;
        end else if (op_i == OP_MUL) begin
            latency_o = LAT_W'(MUL_CYCLES);
        end else if (op_i == OP_DIV) begin
`ifdef ALU_SEQ_DIV0_TRAP_EN
            if (b_is_zero_i) begin
                illegal_o = 1'b1;
            end else begin
                latency_o = LAT_W'(DIV_CYCLES);
            end
`else
            latency_o = LAT_W'(DIV_CYCLES);
`endif
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle issue controller in front of the combinational ALU. Accepts one
// operation over a valid/ready request channel, holds operands and opcode
// stable for an opcode-dependent settle time, captures the 64-bit result into
// Z_HI/Z_LO and returns it over a valid/ready response channel.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op, req_a, req_b       request opcode and operands
//   alu_a, alu_b, alu_op       registered operands/opcode to the ALU
//   alu_c                      ALU result
//   rsp_valid/rsp_ready        response handshake
//   z_hi, z_lo, rsp_err        captured result and error flag
//   busy                       controller not in IDLE
// Build option: ALU_SEQ_DIV0_TRAP_EN (see alu_lat_decode).
//
// state   | meaning
// IDLE    | ready for a request
// EXEC    | operands held, counting down the settle time
// RESP    | result captured, waiting for rsp_ready
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        rsp_err,
    output logic        busy
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    // One spare bit so the largest latency value fits without wrapping.
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_pend_q;
    logic [31:0]       alu_a_q;
    logic [31:0]       alu_b_q;
    logic [4:0]        alu_op_q;
    logic [31:0]       z_hi_q;
    logic [31:0]       z_lo_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;

    logic [CNT_W-1:0]  dec_lat;
    logic              dec_illegal;

    alu_lat_decode #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .LAT_W      (CNT_W)
    ) u_lat_decode (
        .op_i        (req_op),
        .b_is_zero_i (req_b == 32'd0),
        .latency_o   (dec_lat),
        .illegal_o   (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_pend_q  <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            z_hi_q      <= '0;
            z_lo_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_a_q    <= req_a;
                        alu_b_q    <= req_b;
                        alu_op_q   <= req_op;
                        cnt_q      <= dec_lat - CNT_W'(1);
                        err_pend_q <= dec_illegal;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        if (err_pend_q) begin
                            z_hi_q <= '0;
                            z_lo_q <= '0;
                        end else begin
                            z_hi_q <= alu_c[63:32];
                            z_lo_q <= alu_c[31:0];
                        end
                        rsp_err_q   <= err_pend_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign z_hi      = z_hi_q;
    assign z_lo      = z_lo_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Scoreboard bench for alu_sequencer: expected {Z, err, latency} entries are
// queued as requests are accepted and popped when rsp_valid rises.
// Honours ALU_SEQ_DIV0_TRAP_EN for the divide-by-zero expectations.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [63:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [63:0] z;
        logic        err;
        int          acc;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          last_acc = 0;
    logic        rsp_seen = 1'b0;
    logic [31:0] hold_a   = '0;
    logic [31:0] hold_b   = '0;
    logic [4:0]  hold_op  = '0;

    alu_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .z_hi      (z_hi),
        .z_lo      (z_lo),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU stand-in driven by the sequencer's registered operands.
    always_comb begin
        alu_c = 64'hBAD0_BAD0_BAD0_BAD0;
        case (alu_op)
            5'h01: alu_c = {32'h0, alu_a + alu_b};
            5'h02: alu_c = {32'h0, alu_a - alu_b};
            5'h0A: alu_c = {32'h0, alu_a} * {32'h0, alu_b};
            5'h0B: alu_c = (alu_b == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                             : {alu_a % alu_b, alu_a / alu_b};
            5'h0D: alu_c = {32'h0, ~alu_a};
            default: alu_c = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare on the first cycle a response appears.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && !rsp_seen) begin
            chk("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.tag, "_z"},   {z_hi, z_lo}, e.z);
                chk({e.tag, "_err"}, 64'(rsp_err), 64'(e.err));
                chk({e.tag, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
            end
        end
        rsp_seen <= rsp_valid;
    end

    // Operands/opcode must stay put for the whole EXEC and RESP phase.
    always @(negedge clk) begin
        if (rst_n && busy) begin
            chk("hold_a",  64'(alu_a),  64'(hold_a));
            chk("hold_b",  64'(alu_b),  64'(hold_b));
            chk("hold_op", 64'(alu_op), 64'(hold_op));
        end
    end

    task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] ez, input logic eerr,
                         input int elat);
        int n;
        n = 0;
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 64'(req_ready), 64'd1);
        if (req_ready) begin
            hold_a  = a;
            hold_b  = b;
            hold_op = op;
            last_acc = cyc + 1;
            sb_q.push_back('{z: ez, err: eerr, acc: cyc + 1, lat: elat, tag: tag});
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc1;
        int          n;
        logic [63:0] ez;
        logic        eerr;
        int          elat;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_alu_a",     64'(alu_a),     64'd0);
        chk("rst_alu_b",     64'(alu_b),     64'd0);
        chk("rst_alu_op",    64'(alu_op),    64'd0);
        chk("rst_z",         {z_hi, z_lo},   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle op, back-to-back: next accept three edges later.
        issue("add", 5'h01, 32'd5, 32'd7, 64'd12, 1'b0, 1);
        acc1 = last_acc;
        issue("add2", 5'h01, 32'd1, 32'd2, 64'd3, 1'b0, 1);
        chk("add_reaccept_gap", 64'(last_acc - acc1), 64'd3);
        drain();

        issue("sub", 5'h02, 32'd10, 32'd3, 64'd7, 1'b0, 1);
        issue("not", 5'h0D, 32'h0000_000F, 32'd0, 64'h0000_0000_FFFF_FFF0, 1'b0, 1);
        issue("mul", 5'h0A, 32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE, 1'b0, 4);
        drain();

        // DIV with the consumer stalling for five cycles.
        rsp_ready = 1'b0;
        issue("div", 5'h0B, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 8);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_z",         {z_hi, z_lo},   {32'd2, 32'd14});
            req_op    = 5'h01;
            req_a     = 32'h1234;
            req_valid = (i % 2 == 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Illegal opcodes, including the first one above the legal range.
        issue("ill_1f", 5'b11111, 32'd3, 32'd4, 64'd0, 1'b1, 1);
        issue("ill_00", 5'b00000, 32'd3, 32'd4, 64'd0, 1'b1, 1);
        issue("ill_0e", 5'b01110, 32'd3, 32'd4, 64'd0, 1'b1, 1);
        issue("add3", 5'h01, 32'd9, 32'd9, 64'd18, 1'b0, 1);
        drain();

`ifdef ALU_SEQ_DIV0_TRAP_EN
        ez = 64'd0;
        eerr = 1'b1;
        elat = 1;
`else
        ez = 64'hFFFF_FFFF_FFFF_FFFF;
        eerr = 1'b0;
        elat = 8;
`endif
        issue("div0", 5'h0B, 32'd55, 32'd0, ez, eerr, elat);
        drain();

        // Reset during DIV execution aborts the operation.
        issue("div_abort", 5'h0B, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0, 8);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_busy",      64'(busy),      64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_z",         {z_hi, z_lo},   64'd0);
        chk("abort_alu_a",     64'(alu_a),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_rsp", 64'(rsp_valid), 64'd0);

        issue("post_rst_add", 5'h01, 32'd20, 32'd22, 64'd42, 1'b0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue controller in front of the combinational 32-bit `ALU` (A, B, 5-bit `ALU_op`, 64-bit C).
- Accepts one operation at a time from the control unit over a valid/ready request channel.
- Holds the ALU operands and opcode stable for an opcode-dependent number of cycles, so MUL/DIV get multicycle settle paths.
- Captures the 64-bit result into Z_HI/Z_LO and returns it over a valid/ready response channel.
- Sits between the CU and the datapath's Z register pair.

## Interface
Parameters:
- `MUL_CYCLES`, 4: cycles C is allowed to settle for MUL (min 1)
- `DIV_CYCLES`, 8: cycles C is allowed to settle for DIV (min 1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept (high only in IDLE)
- `req_op`  in  5  opcode
- `req_a`, `req_b`  in  32 each  operands
- `alu_a`, `alu_b`  out  32 each  registered operands driven to ALU A/B
- `alu_op`  out  5  registered opcode driven to ALU_op
- `alu_c`  in  64  ALU result C
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `z_hi`, `z_lo`  out  32 each  captured C[63:32], C[31:0]
- `rsp_err`  out  1  illegal opcode (or div-by-zero, see Configuration)
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: load `alu_a`/`alu_b`/`alu_op` from the request, load `cnt` = latency-1, go to EXEC.
- Latency by opcode:
  - MUL (5'b01010) = `MUL_CYCLES`; DIV (5'b01011) = `DIV_CYCLES`.
  - Every other legal opcode = 1.
  - Illegal opcode (0, or >5'b01101) = 1.
- EXEC:
  - `alu_*` held constant; `cnt` decrements each cycle.
  - When `cnt`==0: capture `alu_c` into `z_hi`/`z_lo`, set `rsp_err` (illegal opcode → Z forced to 64'h0, `rsp_err`=1), go to RESP.
- RESP:
  - `rsp_valid`=1; Z and `rsp_err` held.
  - When `rsp_ready`=1: go to IDLE and clear `rsp_valid`.
  - Z keeps its last value until the next capture.
- `req_valid` outside IDLE is ignored; `req_ready`=0 there, so nothing is lost.
- Counter width is $clog2(max(`MUL_CYCLES`, `DIV_CYCLES`)) + 1; no wrap is possible.

## Timing
- Reset values (async, immediate):
  - state=IDLE, so `req_ready`=1.
  - `busy`=0, `rsp_valid`=0, `rsp_err`=0.
  - `alu_a`=`alu_b`=0, `alu_op`=0, `z_hi`=`z_lo`=0, `cnt`=0.
- Accept edge T (`req_valid` & `req_ready`); `alu_*` are valid after T.
- Latency-L op: capture at edge T+L; `rsp_valid` is high from T+L until the edge where `rsp_ready` is sampled high.
  - Single-cycle op with `rsp_ready` held 1: `rsp_valid` is high for one cycle, and the next accept is possible at T+3.
- `rsp_ready` high before `rsp_valid` is harmless and does not pre-complete the response.
- Reset asserted in EXEC or RESP aborts the op; no response is ever produced for it.
- Outputs are all registered except `req_ready`/`busy`, which are decoded from state only, with no combinational path from inputs.

## Configuration
- `ALU_SEQ_DIV0_TRAP_EN` defined:
  - DIV with `req_b`==0 gets latency 1 instead of `DIV_CYCLES`.
  - Capture forces Z=64'h0 and `rsp_err`=1.
- Undefined:
  - DIV by zero runs the full `DIV_CYCLES`.
  - Z takes whatever `alu_c` presents, and `rsp_err`=0.

## Structure
- Shared package `alu_pkg`:
  - opcode constants: ADD 01, SUB 02, AND 03, OR 04, SHR 05, SHRA 06, SHL 07, ROR 08, ROL 09, MUL 0A, DIV 0B, NEG 0C, NOT 0D;
  - state typedef;
  - `OP_LAST` = 5'b01101.
- One sub-module `alu_lat_decode`: combinational opcode (+ `b_is_zero`) → {latency, illegal}. The ALU is instantiated by the datapath, not inside this block.

## Test plan
- ADD, a=5, b=7, `rsp_ready`=1, ALU C model = a+b → `rsp_valid` at T+1, Z={0,12}, `rsp_err`=0; next accept at T+3.
- MUL with `MUL_CYCLES`=4, a=32'hFFFF_FFFF, b=2 → `alu_*` stable T..T+4, `rsp_valid` at T+4, Z=64'h1_FFFF_FFFE.
- DIV 100/7, `rsp_ready` held 0 for 5 cycles → `rsp_valid` and Z hold across all 5; `req_valid` pulses meanwhile are not accepted (`req_ready`=0).
- `req_op`=5'b11111 → `rsp_err`=1, Z=0 at T+1.
- DIV b=0: with `ALU_SEQ_DIV0_TRAP_EN` → `rsp_valid` at T+1, `rsp_err`=1, Z=0; without it → `rsp_valid` at T+8, `rsp_err`=0.
- `rst_n` low mid-EXEC of DIV → immediately state=IDLE, `rsp_valid`=0, Z=0; no response after reset release.
